// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU in EX: one quotient bit per cycle,
// producing {remainder, quotient} for HI/LO with a start/ready hold handshake.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic [1:0]  dbg_state_o
);

  // Handshake: start_i is held high from request until the result is consumed;
  // ready_o marks result_o valid, and dropping start_i while ready_o=1 releases it.
  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_BYZERO = 2'd1,
    ST_DIVON  = 2'd2,
    ST_END    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic        s1_in, s2_in;
  logic [31:0] op1_abs, op2_abs;
  logic [32:0] diff;
  logic [31:0] quot_fix, rem_fix;

  assign s1_in   = signed_div_i & opdata1_i[31];
  assign s2_in   = signed_div_i & opdata2_i[31];
  assign op1_abs = s1_in ? (~opdata1_i + 32'd1) : opdata1_i;
  assign op2_abs = s2_in ? (~opdata2_i + 32'd1) : opdata2_i;

  // Zero-extended subtract; bit 32 set means the partial remainder is below the divisor.
  assign diff     = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
  assign quot_fix = (s1_q ^ s2_q) ? (~work_q[31:0] + 32'd1) : work_q[31:0];
  assign rem_fix  = s1_q ? (~work_q[64:33] + 32'd1) : work_q[64:33];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      ST_FREE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = ST_BYZERO;
          end else begin
            state_d   = ST_DIVON;
            s1_d      = s1_in;
            s2_d      = s2_in;
            divisor_d = op2_abs;
            work_d    = {32'b0, op1_abs, 1'b0};
            cnt_d     = 6'd0;
          end
        end
      end
      ST_BYZERO: begin
        state_d  = ST_END;
        result_d = 64'b0;
        ready_d  = 1'b1;
      end
      ST_DIVON: begin
        if (annul_i) begin
          state_d = ST_FREE;
          cnt_d   = 6'd0;
        end else if (cnt_q != 6'd32) begin
          if (diff[32]) begin
            work_d = {work_q[63:0], 1'b0};
          end else begin
            work_d = {diff[31:0], work_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          state_d  = ST_END;
          result_d = {rem_fix, quot_fix};
          ready_d  = 1'b1;
          cnt_d    = 6'd0;
        end
      end
      ST_END: begin
        if (!start_i) begin
          state_d  = ST_FREE;
          result_d = 64'b0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = ST_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FREE;
      cnt_q     <= 6'd0;
      work_q    <= 65'b0;
      divisor_q <= 32'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      result_q  <= 64'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases from the divider's rules plus
// randomized DIV/DIVU checked against an arithmetic reference model.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic [1:0]  dbg_state_o;

  int n_cmp;
  int n_bad;
  logic [63:0] exp_q[$];

  div_unit dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .dbg_state_o (dbg_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit integer division, truncating toward zero.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    longint la, lb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sgn) begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
    end else begin
      la = longint'({32'b0, a});
      lb = longint'({32'b0, b});
    end
    q = la / lb;
    r = la % lb;
    return {r[31:0], q[31:0]};
  endfunction

  // Full transaction: request, wait for ready with bounded budget, check latency,
  // result, hold while start stays high, and release.
  task automatic do_div(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic scramble);
    int n;
    int lat;
    logic seen;
    logic [63:0] exp;
    logic [63:0] got;
    exp_q.push_back(model(a, b, sgn));
    lat = (b == 32'd0) ? 2 : 34;
    opdata1_i    = a;
    opdata2_i    = b;
    signed_div_i = sgn;
    start_i      = 1'b1;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      step();
      n++;
      if (scramble && n == 1) begin
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = $urandom_range(0, 1);
      end
      if (ready_o) seen = 1'b1;
    end
    n_cmp++;
    if (!seen || n != lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d edges (seen=%0b), required %0d", name, n, seen, lat);
    end
    exp = exp_q.pop_front();
    n_cmp++;
    if (result_o !== exp) begin
      n_bad++;
      $display("FAIL %s result: got %h, required %h", name, result_o, exp);
    end
    got = result_o;
    step();
    n_cmp++;
    if (ready_o !== 1'b1 || result_o !== got) begin
      n_bad++;
      $display("FAIL %s hold: ready=%b result=%h, required ready=1 result=%h",
               name, ready_o, result_o, got);
    end
    start_i = 1'b0;
    step();
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_bad++;
      $display("FAIL %s release: ready=%b result=%h, required ready=0 result=0",
               name, ready_o, result_o);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start_i = 1'b0;
    annul_i = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i = 32'd0;
    opdata2_i = 32'd0;
    repeat (3) step();
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_bad++;
      $display("FAIL reset_state: ready=%b result=%h, required ready=0 result=0",
               ready_o, result_o);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_unsigned();
    do_div("divu_100_7", 32'd100, 32'd7, 1'b0, 1'b0);
    n_cmp++;
    if (model(32'd100, 32'd7, 1'b0) !== 64'h00000002_0000000E) begin
      n_bad++;
      $display("FAIL model_divu_100_7: got %h, required %h",
               model(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
    end
  endtask

  task automatic test_signed();
    do_div("div_m7_2", 32'hFFFFFFF9, 32'h00000002, 1'b1, 1'b0);
    do_div("div_7_m2", 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0);
  endtask

  task automatic test_byzero();
    do_div("divu_5_0", 32'd5, 32'd0, 1'b0, 1'b0);
    do_div("div_m1_0", 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic test_annul();
    int rdy_cnt;
    opdata1_i    = 32'hFFFFFFFF;
    opdata2_i    = 32'd3;
    signed_div_i = 1'b0;
    start_i      = 1'b1;
    repeat (10) step();
    annul_i = 1'b1;
    start_i = 1'b0;
    step();
    annul_i = 1'b0;
    rdy_cnt = 0;
    repeat (40) begin
      step();
      if (ready_o) rdy_cnt++;
    end
    n_cmp++;
    if (rdy_cnt != 0) begin
      n_bad++;
      $display("FAIL annul_no_ready: ready high for %0d cycles, required 0", rdy_cnt);
    end
    do_div("divu_after_annul", 32'hFFFFFFFF, 32'd3, 1'b0, 1'b0);
  endtask

  task automatic test_start_annul_free();
    int rdy_cnt;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd5;
    signed_div_i = 1'b0;
    start_i      = 1'b1;
    annul_i      = 1'b1;
    rdy_cnt      = 0;
    repeat (40) begin
      step();
      if (ready_o) rdy_cnt++;
    end
    n_cmp++;
    if (rdy_cnt != 0) begin
      n_bad++;
      $display("FAIL start_annul_free: ready high for %0d cycles, required 0", rdy_cnt);
    end
    start_i = 1'b0;
    annul_i = 1'b0;
    step();
  endtask

  task automatic test_boundary();
    do_div("div_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1);
    do_div("divu_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b1);
    do_div("div_min_1", 32'h80000000, 32'd1, 1'b1, 1'b0);
    do_div("divu_small_big", 32'd3, 32'hFFFFFFFF, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    opdata1_i    = 32'h12345678;
    opdata2_i    = 32'd9;
    signed_div_i = 1'b0;
    start_i      = 1'b1;
    repeat (20) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_bad++;
      $display("FAIL mid_reset: ready=%b result=%h, required ready=0 result=0",
               ready_o, result_o);
    end
    // start_i stays high, so the next edge begins a fresh division.
    do_div("restart_after_rst", 32'h12345678, 32'd9, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic sgn;
    for (int i = 0; i < 24; i++) begin
      a   = $urandom;
      b   = $urandom;
      sgn = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0: b = $urandom_range(1, 15);
        1: b = 32'd0;
        2: a = {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'd0};
        3: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      do_div("random", a, b, sgn, $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic test_back_to_back();
    do_div("b2b_0", 32'd1000, 32'd10, 1'b0, 1'b0);
    do_div("b2b_1", 32'hFFFFFC18, 32'd10, 1'b1, 1'b0);
    do_div("b2b_2", 32'd1000, 32'hFFFFFFF6, 1'b1, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_byzero();
    test_annul();
    test_start_annul_free();
    test_boundary();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Multi-cycle radix-2 restoring divider serving the EX stage of the 5-stage MIPS pipeline. It executes DIV/DIVU on the operands EX receives from the ID/EX register and returns a 64-bit {remainder, quotient} result destined for HI/LO. It takes one quotient bit per cycle. EX holds start_i high and asserts its stall request while ready_o is low, which freezes ID/EX and upstream stages.

## Interface
- No parameters; operand width fixed at 32 bits.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  division request from EX; held high until the result is consumed.
- annul_i  in  1  cancel request (e.g. flush); aborts any division in progress.
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU.
- opdata1_i  in  32  dividend.
- opdata2_i  in  32  divisor.
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid only while ready_o=1.
- ready_o  out  1  result valid.

## Operation
- States: FREE, BYZERO, DIVON, END. Reset → FREE, cnt=0, result_o=0, ready_o=0.
- FREE:
  - start_i=1 and annul_i=0 with opdata2_i=0 → BYZERO.
  - start_i=1 and annul_i=0 with opdata2_i≠0 → DIVON:
    - Latch sign flags s1=signed_div_i&opdata1_i[31] and s2=signed_div_i&opdata2_i[31], plus signed_div_i.
    - Latch divisor |op2|; |x| is the two's complement of x when its sign flag is set, else x unchanged.
    - Load the 65-bit working register with {32'b0, |op1|, 1'b0}; set cnt=0.
  - Otherwise remain in FREE.
- BYZERO: next edge → END with result_o=64'b0.
- DIVON:
  - annul_i=1 → FREE; working state discarded; ready_o stays 0.
  - cnt<32: compute diff = work[63:32] − divisor at 33-bit width.
    - diff negative → work <= work<<1.
    - Otherwise → work <= {diff[31:0], work[31:0], 1'b1}.
    - cnt <= cnt+1.
  - cnt=32 → END:
    - quotient = work[31:0], negated if s1^s2.
    - remainder = work[64:33], negated if s1.
    - result_o <= {remainder, quotient}; ready_o <= 1.
- END:
  - start_i=1 → hold; result_o and ready_o are stable.
  - start_i=0 → FREE, result_o <= 0, ready_o <= 0.
- Sign rules:
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - Arithmetic wraps mod 2^32. 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0.
- annul_i is ignored in BYZERO and END. In FREE it blocks start.
- Operands are latched at start. Changes on opdata*_i after start have no effect.

## Timing
- Let E0 be the edge where start is sampled in FREE.
- Normal divide:
  - E0 → DIVON (cnt=0).
  - E1..E32: one iteration per edge.
  - E33 → END, ready_o=1.
  - Latency is 33 edges after E0.
- Divide by zero: E0 → BYZERO, E1 → END; ready_o=1 after E1.
- ready_o and result_o are registered; there is no combinational path from any input to any output.
- Release: start_i low at edge Ek in END → ready_o=0 after Ek.
- Back-to-back: a new start is accepted at the edge after return to FREE, so there is a minimum one idle cycle between results.
- rst has priority over annul_i and start_i in every state. rst mid-division → FREE, outputs 0 after that edge.
- Simultaneous annul_i and start_i in FREE → stay FREE.

## Test plan
- Unsigned divide: DIVU 100/7, start held → ready_o rises exactly 33 edges after E0; result_o=0x00000002_0000000E.
- Signed divide: DIV −7/2 (0xFFFFFFF9/0x00000002) → result_o=0xFFFFFFFF_FFFFFFFD. Then DIV 7/−2 → 0x00000001_FFFFFFFD.
- Divide by zero: DIVU 5/0 → ready_o=1 after E1, result_o=0. Deassert start_i → ready_o=0 and result_o=0 next edge.
- Annul: DIVU 0xFFFFFFFF/3 with annul_i pulsed at E10 → FREE, ready_o never asserts. A fresh DIVU 0xFFFFFFFF/3 then yields 0x00000000_55555555 at E0+33.
- Boundary values: DIV 0x80000000/0xFFFFFFFF → 0x00000000_80000000. DIVU 0xFFFFFFFF/1 → 0x00000000_FFFFFFFF. Operands changed after E0 do not alter either result.
- Reset: rst asserted at E20 of a division → FREE, ready_o=0, result_o=0 next edge. start_i still high → a new division begins at the following edge.
